// File: rtl/widen_rr_sched.sv
// Round-robin scheduler sharing one sign/zero-extending width converter between NREQ requesters.
// The winning value is widened and held in a single output register behind valid/ready.
module widen_rr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 8,
  localparam int unsigned SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_signed,
  input  logic [NREQ*IN_W-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic [15:0]            grant_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [SRC_W-1:0]   out_src_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [15:0]        grant_cnt_q;

  logic               space;
  logic               grant;
  logic               winner_vld;
  logic [SRC_W-1:0]   winner_idx;
  logic [IN_W-1:0]    sel_data;
  logic               sel_signed;
  logic [OUT_W-1:0]   ext_data;

  // Space exists when the register is free or is being drained this cycle.
  assign space = (state_q == StEmpty) || out_ready;

  // Rotating priority search: first valid requester at or after ptr, wrapping.
  always_comb begin
    logic [31:0]      idx;
    logic [SRC_W-1:0] idx_s;
    winner_vld = 1'b0;
    winner_idx = '0;
    idx        = '0;
    idx_s      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (32'(ptr_q) + k) % NREQ;
      idx_s = SRC_W'(idx);
      if (!winner_vld && req_valid[idx_s]) begin
        winner_vld = 1'b1;
        winner_idx = idx_s;
      end
    end
  end

  assign grant     = space && winner_vld;
  assign req_ready = grant ? (NREQ'(1) << winner_idx) : '0;

  assign sel_data   = req_data[winner_idx*IN_W +: IN_W];
  assign sel_signed = req_signed[winner_idx];
  assign ext_data   = {{(OUT_W - IN_W){sel_signed & sel_data[IN_W-1]}}, sel_data};

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (winner_idx == SRC_W'(NREQ - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (grant) state_d = StFull;
      end
      StFull: begin
        if (grant)          state_d = StFull;
        else if (out_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_q == StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant) begin
        out_src_q   <= winner_idx;
        out_data_q  <= ext_data;
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign grant_cnt = grant_cnt_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

  a_no_grant_when_blocked : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |-> (req_ready == '0));

endmodule

// File: tb/tb_widen_rr_sched.sv
// Scoreboard bench for widen_rr_sched: a queue-based model predicts grants and widened outputs,
// a negedge monitor compares the DUT output register against the queue head.
module tb_widen_rr_sched;
  localparam int NREQ  = 4;
  localparam int IN_W  = 4;
  localparam int OUT_W = 8;
  localparam int SRC_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_signed, req_ready;
  logic [NREQ*IN_W-1:0] req_data;
  logic                 out_valid, out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [SRC_W-1:0]     out_src;
  logic [15:0]          grant_cnt;

  widen_rr_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_signed(req_signed),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int src;} exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   mptr = 0;
  int   mcnt = 0;
  bit   pend = 0;
  exp_t pend_e;
  int   last_winner = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Widening as arithmetic: a signed value with the top bit set is negative, wrapped mod 2^OUT_W.
  function automatic int extend(input int val, input bit sgn);
    if (sgn && val >= (1 << (IN_W - 1))) return val - (1 << IN_W) + (1 << OUT_W);
    return val;
  endfunction

  task automatic apply_pending();
    if (pend) begin
      q.push_back(pend_e);
      mcnt = (mcnt + 1) % 65536;
      pend = 0;
    end
    check("grant_cnt", grant_cnt, mcnt);
  endtask

  task automatic decide();
    int w = -1;
    bit space = (q.size() == 0) || out_ready;
    if (space) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (mptr + k) % NREQ;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    check("req_ready", req_ready, (w >= 0) ? (1 << w) : 0);
    last_winner = w;
    if (w >= 0) begin
      pend        = 1;
      pend_e.data = extend(int'(req_data[w*IN_W +: IN_W]), req_signed[w]);
      pend_e.src  = w;
      mptr        = (w + 1) % NREQ;
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] s,
                       input logic [NREQ*IN_W-1:0] d, input logic r);
    @(posedge clk);
    #1;
    apply_pending();
    req_valid  = v;
    req_signed = s;
    req_data   = d;
    out_ready  = r;
    #1;
    decide();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    q.delete();
    pend = 0;
    mptr = 0;
    mcnt = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("out_data", out_data, q[0].data);
        check("out_src", out_src, q[0].src);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [NREQ-1:0]      v, s;
    logic [NREQ*IN_W-1:0] d;
    int                   exp_src[6] = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0; req_valid = '0; req_signed = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_out_src", out_src, 0);
    check("init_grant_cnt", grant_cnt, 0);
    req_valid = 4'b0001;
    #1 check("init_req_ready_comb", req_ready, 4'b0001);
    req_valid = '0;
    #1 rst_n = 1'b1;

    // Signed extension from requester 0
    cycle(4'b0001, 4'b0001, 16'h000F, 1'b1);
    cycle('0, '0, '0, 1'b1);
    check("sgn_data", out_data, 8'hFF);
    check("sgn_src", out_src, 0);
    check("sgn_cnt", grant_cnt, 1);

    // Zero then sign extension from requester 2
    cycle(4'b0100, 4'b0000, 16'h0A00, 1'b1);
    cycle('0, '0, '0, 1'b1);
    check("zext_data", out_data, 8'h0A);
    check("zext_src", out_src, 2);
    cycle(4'b0100, 4'b0100, 16'h0A00, 1'b1);
    cycle('0, '0, '0, 1'b1);
    check("sext_data", out_data, 8'hFA);

    // Fairness from a fresh pointer
    do_reset();
    for (int j = 0; j < 6; j++) begin
      cycle(4'hF, 4'h0, 16'h4321, 1'b1);
      check("fair_grant", req_ready, 1 << exp_src[j]);
      if (j > 0) check("fair_valid", out_valid, 1);
    end

    // Backpressure, then drain-and-refill
    repeat (5) begin
      cycle(4'hF, 4'h0, 16'h4321, 1'b0);
      check("bp_req_ready", req_ready, 0);
      check("bp_src", out_src, 1);
    end
    cycle(4'b0010, 4'b0000, 16'h0050, 1'b1);
    check("refill_grant", req_ready, 4'b0010);
    cycle('0, '0, '0, 1'b1);
    check("refill_valid", out_valid, 1);
    check("refill_data", out_data, 8'h05);

    // Reset while holding 0x07
    cycle(4'b0001, 4'b0000, 16'h0007, 1'b0);
    cycle('0, '0, '0, 1'b0);
    check("pre_rst_data", out_data, 8'h07);
    check("pre_rst_valid", out_valid, 1);
    #1 do_reset();
    cycle(4'b1010, 4'b0000, 16'h5030, 1'b1);
    check("post_rst_grant", req_ready, 4'b0010);
    cycle('0, '0, '0, 1'b1);

    // Randomized traffic; an offer is held until granted or occasionally withdrawn
    v = '0; s = '0; d = '0;
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            v[i] = 1'b1;
            s[i] = 1'($urandom);
            d[i*IN_W +: IN_W] = IN_W'($urandom);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          v[i] = 1'b0;
        end
      end
      cycle(v, s, d, $urandom_range(0, 3) != 0);
      if (last_winner >= 0) v[last_winner] = 1'b0;
    end

    // Counter wrap
    while (((mcnt + int'(pend)) % 65536) != 65535) cycle(4'b0001, 4'b0001, 16'h0003, 1'b1);
    cycle('0, '0, '0, 1'b1);
    check("cnt_ffff", grant_cnt, 16'hFFFF);
    cycle(4'b0001, 4'b0000, 16'h0009, 1'b1);
    cycle('0, '0, '0, 1'b1);
    check("cnt_wrap", grant_cnt, 16'h0000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
